// File: rtl/ldm_stm_seq_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_WBASE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int unsigned ADDR_STEP = 4;
    localparam logic [3:0]  PC_CODE   = 4'hF;

endpackage

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit index and population count of a 16-entry register list.
module lsm_prio_enc
    import ldm_stm_seq_pkg::*;
(
    input  logic [15:0] i_list,
    output logic [3:0]  o_low_c,
    output logic [4:0]  o_cnt_c
);

    // Scan from the PC downwards so the last hit is the lowest register.
    always_comb begin
        o_low_c = 4'd0;
        o_cnt_c = 5'd0;
        for (int i = int'(PC_CODE); i >= 0; i--) begin
            if (i_list[i]) begin
                o_low_c = 4'(i);
                o_cnt_c = o_cnt_c + 5'd1;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM multi-register transfer sequencer with optional base writeback.
// Base writeback is built only when LDM_STM_BASE_WB_EN is defined.
module ldm_stm_seq #(
    parameter int unsigned ADDR_STEP = ldm_stm_seq_pkg::ADDR_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        i_start,
    input  logic        i_load,
    input  logic        i_up,
    input  logic        i_pre,
    input  logic        i_wb,
    input  logic [3:0]  i_base_code,
    input  logic [31:0] i_base,
    input  logic [15:0] i_reg_list,
    output logic [3:0]  o_re_code,
    input  logic [31:0] i_re_reg,
    output logic        o_mem_req,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rd_en_wb,
    output logic [3:0]  o_rd_code_wb,
    output logic [31:0] o_rd_reg_wb,
    output logic        o_busy,
    output logic        o_done
);

    import ldm_stm_seq_pkg::*;

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    state_t      r_state, w_next;
    logic [15:0] r_list;
    logic [31:0] r_addr, r_base;
    logic [4:0]  r_cnt;
    logic [3:0]  r_base_code;
    logic        r_load, r_up, r_wb;
    logic        r_wb_en;
    logic [3:0]  r_wb_code;
    logic [31:0] r_wb_data;

    logic [15:0] w_enc_list;
    logic [3:0]  w_low;
    logic [4:0]  w_cnt;
    logic [31:0] w_span, w_start_addr, w_span_q, w_base_new;
    logic        w_wb_req;

    // In IDLE the encoder sizes the incoming list; afterwards it tracks pending registers.
    assign w_enc_list = (r_state == S_IDLE) ? i_reg_list : r_list;

    lsm_prio_enc u_prio (
        .i_list  (w_enc_list),
        .o_low_c (w_low),
        .o_cnt_c (w_cnt)
    );

    always_comb begin
        w_span = 32'(w_cnt) * STEP;
        case ({i_up, i_pre})
            2'b10:   w_start_addr = i_base;
            2'b11:   w_start_addr = i_base + STEP;
            2'b00:   w_start_addr = i_base - w_span + STEP;
            default: w_start_addr = i_base - w_span;
        endcase
    end

    assign w_span_q   = 32'(r_cnt) * STEP;
    assign w_base_new = r_up ? (r_base + w_span_q) : (r_base - w_span_q);

`ifdef LDM_STM_BASE_WB_EN
    // A loaded base register takes precedence over the writeback value.
    assign w_wb_req = i_wb & ~(i_load & i_reg_list[i_base_code]);
`else
    // Writeback compiled out: i_wb has no effect.
    assign w_wb_req = i_wb & 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_mem_req   = 1'b0;
        o_mem_wr    = 1'b0;
        o_mem_addr  = 32'd0;
        o_re_code   = 4'd0;
        o_mem_wdata = 32'd0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = (w_cnt == 5'd0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                o_mem_req  = 1'b1;
                o_mem_wr   = ~r_load;
                o_mem_addr = r_addr;
                if (!r_load) begin
                    o_re_code   = w_low;
                    o_mem_wdata = i_re_reg;
                end
                if (i_mem_ack && (w_cnt == 5'd1)) begin
                    w_next = r_wb ? S_WBASE : S_DONE;
                end
            end
            S_WBASE: w_next = S_DONE;
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Register-file writes land one cycle after their cause, so the base write trails the last load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_list      <= 16'd0;
            r_addr      <= 32'd0;
            r_base      <= 32'd0;
            r_cnt       <= 5'd0;
            r_base_code <= 4'd0;
            r_load      <= 1'b0;
            r_up        <= 1'b0;
            r_wb        <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_code   <= 4'd0;
            r_wb_data   <= 32'd0;
        end else if (en) begin
            r_wb_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_list      <= i_reg_list;
                        r_addr      <= w_start_addr;
                        r_base      <= i_base;
                        r_cnt       <= w_cnt;
                        r_base_code <= i_base_code;
                        r_load      <= i_load;
                        r_up        <= i_up;
                        r_wb        <= w_wb_req;
                    end
                end
                S_XFER: begin
                    if (i_mem_ack) begin
                        r_list[w_low] <= 1'b0;
                        r_addr        <= r_addr + STEP;
                        if (r_load) begin
                            r_wb_en   <= 1'b1;
                            r_wb_code <= w_low;
                            r_wb_data <= i_mem_rdata;
                        end
                    end
                end
                S_WBASE: begin
                    r_wb_en   <= 1'b1;
                    r_wb_code <= r_base_code;
                    r_wb_data <= w_base_new;
                end
                default: ;
            endcase
        end
    end

    assign o_rd_en_wb   = r_wb_en;
    assign o_rd_code_wb = r_wb_code;
    assign o_rd_reg_wb  = r_wb_data;

endmodule

// File: doc/ldm_stm_seq.md
LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 SHALL have parameter ADDR_STEP, default 4, meaning the byte increment per transferred word.
REQ-002 SHALL have clk  input  1  clock, rising-edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have en  input  1  pipeline enable; when low, all state is frozen.
REQ-005 SHALL have i_start  input  1  single-cycle launch of a block transfer.
REQ-006 SHALL have i_load  input  1  1=LDM, 0=STM.
REQ-007 SHALL have i_up, i_pre, i_wb  input  1 each  U, P and W bits of the instruction.
REQ-008 SHALL have i_base_code  input  4  base register number.
REQ-009 SHALL have i_base  input  32  base register value, sampled at start.
REQ-010 SHALL have i_reg_list  input  16  register list; bit n selects rn.
REQ-011 SHALL have o_re_code  output  4  register-file read code for STM data; i_re_reg  input  32  returned value, combinational.
REQ-012 SHALL have o_mem_req, o_mem_wr  output  1 each; o_mem_addr, o_mem_wdata  output  32 each; i_mem_ack  input  1; i_mem_rdata  input  32.
REQ-013 SHALL have o_rd_en_wb  output  1, o_rd_code_wb  output  4, o_rd_reg_wb  output  32  register-file WB write port.
REQ-014 SHALL have o_busy, o_done  output  1 each.

Function
REQ-015 SHALL implement FSM states IDLE, XFER, WBASE, DONE.
REQ-016 In IDLE with en=1 and i_start=1, SHALL latch all inputs, set n=popcount(i_reg_list), and go to XFER; if n=0, SHALL go directly to DONE.
REQ-017 SHALL compute the start address as: IA=base, IB=base+4, DA=base-4n+4, DB=base-4n (mod 2^32).
REQ-018 In XFER, SHALL hold o_mem_req=1 and o_mem_wr=!load, with o_mem_addr equal to the current address, until i_mem_ack=1.
REQ-019 SHALL transfer registers in ascending register-number order at ascending addresses.
REQ-020 For STM, SHALL drive o_re_code to the lowest pending register and o_mem_wdata=i_re_reg combinationally.
REQ-021 For LDM, SHALL pulse o_rd_en_wb for one cycle, the cycle after each ack, with the registered code and i_mem_rdata; code 15 is written like any other register.
REQ-022 On each ack, SHALL clear the serviced list bit and add ADDR_STEP to the address; after the last ack, SHALL go to WBASE if writeback is enabled, otherwise DONE.
REQ-023 WBASE SHALL last one cycle: o_rd_en_wb=1, o_rd_code_wb=base_code, o_rd_reg_wb = up ? base+4n : base-4n.
REQ-024 Writeback SHALL be suppressed when load=1 and the base is in the list; the loaded value wins.
REQ-025 The WBASE write SHALL occur after the final LDM data write, never in the same cycle.
REQ-026 DONE SHALL pulse o_done for one cycle, then return to IDLE.
REQ-027 o_busy SHALL be 1 in every state except IDLE.
REQ-028 i_start SHALL be ignored while o_busy=1.
REQ-029 When en=0, the FSM, counters and address SHALL hold; o_mem_req and pending WB pulses SHALL hold their values.

Reset
REQ-030 rst_n low SHALL force IDLE, list, address and count to 0, and all outputs to 0, including mid-transfer; no write pulse SHALL occur after reset.

Configuration
REQ-031 Macro LDM_STM_BASE_WB_EN defined: REQ-023/024 apply when i_wb=1.
REQ-032 Macro LDM_STM_BASE_WB_EN undefined: i_wb is ignored, WBASE is never entered, and the base is never written.

Structure
REQ-033 A shared package SHALL hold the FSM state typedef, ADDR_STEP, and the PC register code constant 4'hF.
REQ-034 A sub-module lsm_prio_enc SHALL compute the lowest-set-bit index and popcount of a 16-bit list.

Verification
REQ-035 STM IA: base=0x1000, list=0x0005, ack every cycle -> writes r0 at 0x1000 and r2 at 0x1004; o_done is high 3 cycles after start.
REQ-036 LDM DB with W: base=0x2000, list=0x8003, rdata 0xA,0xB,0xC -> r0=0xA @0x1FF4, r1=0xB @0x1FF8, r15=0xC @0x1FFC; base written 0x1FF4 in WBASE.
REQ-037 LDM with base in list: base_code=1, list=0x0002, W=1 -> r1 gets the loaded value; no WBASE pulse.
REQ-038 Empty list: list=0x0000 -> no o_mem_req; o_done is high the cycle after start.
REQ-039 Stalls: ack delayed 3 cycles and en low 2 cycles mid-XFER -> o_mem_addr/o_mem_req are held stable; transfer order and count are unchanged.
REQ-040 Reset mid-XFER and i_start while busy -> IDLE with all outputs 0; the ignored start causes no new transfer.
